tx_frame_scheduler: RTL
=======================

# tx_frame_scheduler

Per-frame transmit scheduler for the RIFL link. On every frame slot it chooses which 18-bit code the TX framer sends: a new user data frame, a replayed frame, an idle, or a PAUSE or RETRANS control key. Its choice follows local flow-control and error requests and the remote peer's pause/retransmit requests. It sits beside the TX framer and the replay buffer and is the transmit-side counterpart of the RX control-code decoder.

## Interface
- REPLAY_DEPTH, 64, frames held in the replay buffer; power of 2, ≥2. PTR_W = $clog2(REPLAY_DEPTH).
- KEY_REPEAT, 8, consecutive slots in a control-key burst; 1..15.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sof  in  1  frame-slot strobe, one cycle per slot
- tx_up  in  1  link up; low acts as reset, except that code keeps driving idle
- local_pause  in  1  level; local RX needs the peer to pause
- local_retrans  in  1  pulse, any cycle; local RX detected an error
- remote_pause  in  1  level; peer asked us to pause
- remote_retrans  in  1  level; peer asked for retransmission
- data_valid  in  1  user has a new frame available
- code  out  18  header/key for the current slot
- frame_new  out  1  slot carries a new user frame; acts as the data_ready pulse
- frame_replay  out  1  slot carries a replayed frame
- frame_ptr  out  PTR_W  replay-buffer index written (new) or read (replay)

## Operation
- Code values:
  - DATA = {2'b01,16'h0000}
  - IDLE = {2'b10,16'h0001}
  - PAUSE = {2'b10,16'h0010}
  - RETRANS = {2'b10,16'h1000}
- FSM states: NORMAL, RETRANS_BURST, PAUSE_BURST.
  - A burst sends its key for exactly KEY_REPEAT slots (burst_cnt, 4 bits). It is never preempted, then returns to NORMAL.
- Pending flags:
  - retrans_pend is set by local_retrans in any cycle, including during a burst.
  - retrans_pend is cleared when RETRANS_BURST is entered.
  - A local_retrans pulse during RETRANS_BURST sets retrans_pend again, so one more burst follows. Multiple pulses before a burst starts merge into one.
- Slot decision at sof in NORMAL, highest priority first:
  1. retrans_pend → enter RETRANS_BURST, send RETRANS.
  2. local_pause → enter PAUSE_BURST, send PAUSE.
  3. remote_pause → IDLE; no data or replay is sent.
  4. replay active → DATA with frame_replay=1, frame_ptr=rd_ptr; then rd_ptr+1.
  5. data_valid → DATA with frame_new=1, frame_ptr=wr_ptr; then wr_ptr+1 and sent_cnt+1.
  6. Otherwise IDLE.
- At the end of a PAUSE_BURST with local_pause still high, the next slot re-enters PAUSE_BURST.
- Replay handling:
  - sent_cnt is PTR_W+1 bits and saturates at REPLAY_DEPTH.
  - A rising edge of remote_retrans is edge-detected on the sampled level at each sof. It sets rd_ptr = wr_ptr − sent_cnt (mod REPLAY_DEPTH) and sets replay active.
  - If sent_cnt = 0, no replay starts.
  - A rising edge during an active replay restarts the rewind from the current wr_ptr.
  - Replay ends when the incremented rd_ptr equals wr_ptr.
  - No new frames are accepted while replay is active.
- Pointers are PTR_W bits and wrap modulo REPLAY_DEPTH.
- rst or tx_up low:
  - State goes to NORMAL; burst_cnt, pointers, sent_cnt, retrans_pend, replay and edge history clear.
  - Outputs: code=IDLE, frame_new=0, frame_replay=0, frame_ptr=0.
  - This applies immediately, including mid-burst and mid-replay.

## Timing
- All outputs are registered.
- They update only in the cycle after the sof cycle and hold until the next sof update.
- Inputs are sampled in the sof cycle. local_retrans is the only input latched between slots.
- frame_new is high for exactly one slot per accepted user frame. The user pops its frame on the frame_new slot.
- Latency: a local_retrans pulse in cycle t produces RETRANS at the first sof strictly after t.
- Simultaneous remote_retrans edge and data_valid in the same slot: replay wins, and the new frame is not accepted.

## Test plan
- Reset, then 20 sof slots with no requests → code=IDLE every slot; frame_new, frame_replay and frame_ptr stay 0.
- data_valid high for 5 slots → DATA with frame_new=1 and frame_ptr 0,1,2,3,4; then IDLE.
- local_retrans pulse mid-slot while local_pause is high → 8 RETRANS slots, then PAUSE slots for as long as local_pause stays high, in 8-slot bursts; DATA resumes after local_pause falls and the current burst ends.
- Send 70 new frames (wrap; sent_cnt saturates at 64), then remote_retrans rises → 64 replay slots with frame_ptr 6..63,0..5 and frame_replay=1; then new frames resume at frame_ptr 6.
- remote_pause high during replay → IDLE while it is high; replay continues from the same rd_ptr after it falls.
- tx_up dropped mid-RETRANS_BURST after 3 slots → code=IDLE at once; after tx_up returns, no burst resumes unless a new local_retrans arrives; frame_ptr restarts at 0.

Source files
------------

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: per-slot choice of data, replay, idle or PAUSE/RETRANS key for the RIFL TX framer
module tx_frame_scheduler #(
    parameter int REPLAY_DEPTH = 64,
    parameter int KEY_REPEAT   = 8,
    localparam int PTR_W       = $clog2(REPLAY_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic             tx_up,
    input  logic             local_pause,
    input  logic             local_retrans,
    input  logic             remote_pause,
    input  logic             remote_retrans,
    input  logic             data_valid,
    output logic [17:0]      code,
    output logic             frame_new,
    output logic             frame_replay,
    output logic [PTR_W-1:0] frame_ptr
);
    localparam logic [17:0] DATA    = {2'b01, 16'h0000};
    localparam logic [17:0] IDLE    = {2'b10, 16'h0001};
    localparam logic [17:0] PAUSE   = {2'b10, 16'h0010};
    localparam logic [17:0] RETRANS = {2'b10, 16'h1000};
    localparam logic [3:0] KR = 4'(KEY_REPEAT);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(REPLAY_DEPTH);
    localparam logic [PTR_W-1:0] ONE = PTR_W'(1);
    localparam bit MULTI = KEY_REPEAT > 1;

    typedef enum logic [1:0] {NORMAL, RETRANS_BURST, PAUSE_BURST} state_t;

    state_t           state, state_n;
    logic [3:0]       burst_cnt, burst_cnt_n;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
    logic [PTR_W:0]   sent_cnt, sent_cnt_n;
    logic             retrans_pend, retrans_pend_n;
    logic             replay_act, replay_act_n;
    logic             rr_prev, rr_prev_n;
    logic [17:0]      code_n;
    logic             frame_new_n, frame_replay_n;
    logic [PTR_W-1:0] frame_ptr_n;
    logic             edge_go, act_eff;
    logic [PTR_W-1:0] rd_eff, rd_inc;

    // State and output registers; a dropped link clears everything like reset
    always_ff @(posedge clk) begin
        if (rst || !tx_up) begin
            state        <= NORMAL;
            burst_cnt    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            sent_cnt     <= '0;
            retrans_pend <= 1'b0;
            replay_act   <= 1'b0;
            rr_prev      <= 1'b0;
            code         <= IDLE;
            frame_new    <= 1'b0;
            frame_replay <= 1'b0;
            frame_ptr    <= '0;
        end else begin
            state        <= state_n;
            burst_cnt    <= burst_cnt_n;
            wr_ptr       <= wr_ptr_n;
            rd_ptr       <= rd_ptr_n;
            sent_cnt     <= sent_cnt_n;
            retrans_pend <= retrans_pend_n;
            replay_act   <= replay_act_n;
            rr_prev      <= rr_prev_n;
            code         <= code_n;
            frame_new    <= frame_new_n;
            frame_replay <= frame_replay_n;
            frame_ptr    <= frame_ptr_n;
        end
    end

    // Slot decision: bursts run to completion, then retrans > pause > remote pause > replay > new data
    always_comb begin
        state_n        = state;
        burst_cnt_n    = burst_cnt;
        wr_ptr_n       = wr_ptr;
        rd_ptr_n       = rd_ptr;
        sent_cnt_n     = sent_cnt;
        retrans_pend_n = retrans_pend | local_retrans;
        replay_act_n   = replay_act;
        rr_prev_n      = rr_prev;
        code_n         = code;
        frame_new_n    = frame_new;
        frame_replay_n = frame_replay;
        frame_ptr_n    = frame_ptr;
        edge_go        = sof & remote_retrans & ~rr_prev & (sent_cnt != '0);
        act_eff        = replay_act | edge_go;
        rd_eff         = edge_go ? wr_ptr - sent_cnt[PTR_W-1:0] : rd_ptr;
        rd_inc         = rd_eff + ONE;
        if (sof) begin
            rr_prev_n      = remote_retrans;
            replay_act_n   = act_eff;
            rd_ptr_n       = rd_eff;
            code_n         = IDLE;
            frame_new_n    = 1'b0;
            frame_replay_n = 1'b0;
            frame_ptr_n    = '0;
            if (state != NORMAL) begin
                code_n      = state == RETRANS_BURST ? RETRANS : PAUSE;
                burst_cnt_n = burst_cnt + 4'd1;
                state_n     = burst_cnt_n == KR ? NORMAL : state;
                burst_cnt_n = burst_cnt_n == KR ? 4'd0 : burst_cnt_n;
            end else if (retrans_pend) begin
                code_n         = RETRANS;
                retrans_pend_n = local_retrans;
                state_n        = MULTI ? RETRANS_BURST : NORMAL;
                burst_cnt_n    = MULTI ? 4'd1 : 4'd0;
            end else if (local_pause) begin
                code_n      = PAUSE;
                state_n     = MULTI ? PAUSE_BURST : NORMAL;
                burst_cnt_n = MULTI ? 4'd1 : 4'd0;
            end else if (remote_pause) begin
                code_n = IDLE;
            end else if (act_eff) begin
                code_n         = DATA;
                frame_replay_n = 1'b1;
                frame_ptr_n    = rd_eff;
                rd_ptr_n       = rd_inc;
                replay_act_n   = rd_inc != wr_ptr;
            end else if (data_valid) begin
                code_n      = DATA;
                frame_new_n = 1'b1;
                frame_ptr_n = wr_ptr;
                wr_ptr_n    = wr_ptr + ONE;
                sent_cnt_n  = sent_cnt == DEPTH_C ? sent_cnt : sent_cnt + 1'b1;
            end
        end
    end
endmodule
